addr_alloc: RTL

ADDR_ALLOC -- requirements
Module: addr_alloc

---
 rtl/sram_pkg.sv | 17 +
 rtl/addr_popcnt.sv | 20 ++
 rtl/addr_alloc.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared SRAM block-pool constants and allocator FSM encodings
// Purpose : default pool geometry (DEPTH blocks, ADDR_W-bit block index) and the
//           one-hot allocator state encoding, shared with the address-recycle block.
// Ports   : none (package).
package sram_pkg;

  localparam int DEPTH  = 512;
  localparam int ADDR_W = 9;

  // One-hot so that "not IDLE" is a single inverted flop bit.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_SCAN = 3'b010,
    ST_DONE = 3'b100
  } alloc_state_e;

endpackage

// File: rtl/addr_popcnt.sv
// rtl/addr_popcnt.sv - combinational population count of a block bitmap
// Purpose : counts the set bits of a W-bit vector.
// Ports   : vec_i  [W-1:0]  bitmap to count
//           cnt_o  [CW-1:0] number of ones in vec_i
module addr_popcnt #(
  parameter int W  = sram_pkg::DEPTH,
  parameter int CW = sram_pkg::ADDR_W + 1
) (
  input  logic [W-1:0]  vec_i,
  output logic [CW-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) begin
      cnt_o = cnt_o + CW'(vec_i[i]);
    end
  end

endmodule

// File: rtl/addr_alloc.sv
// rtl/addr_alloc.sv - bitmap-based SRAM block allocator with linear free-block scan
// Purpose : tracks DEPTH blocks in a used bitmap, grants alloc_num free blocks by
//           scanning one bit per cycle from index 0, and frees blocks on rel_req.
// Build   : define ADDR_ALLOC_FREE_CNT_EN to add the free-block counter (free_cnt)
//           and the early reject of requests larger than the free count.
// Ports   : sys_clk / sys_rst         clock, asynchronous active-high reset
//           alloc_req, alloc_num      allocation request and block count (IDLE only)
//           rel_req, rel_mask         release request and blocks to free
//           alloc_busy                high while not IDLE
//           alloc_done                one-cycle completion pulse
//           alloc_ok                  request fully granted (valid with alloc_done)
//           alloc_mask                granted blocks
//           alloc_first_addr          lowest granted block index
//           alloc_grant_cnt           number of blocks found
//           free_cnt                  free blocks (ADDR_ALLOC_FREE_CNT_EN only)
module addr_alloc #(
  parameter int DEPTH  = sram_pkg::DEPTH,
  parameter int ADDR_W = sram_pkg::ADDR_W
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              alloc_req,
  input  logic [ADDR_W:0]   alloc_num,
  input  logic              rel_req,
  input  logic [DEPTH-1:0]  rel_mask,
  output logic              alloc_busy,
  output logic              alloc_done,
  output logic              alloc_ok,
  output logic [DEPTH-1:0]  alloc_mask,
  output logic [ADDR_W-1:0] alloc_first_addr,
  output logic [ADDR_W:0]   alloc_grant_cnt
`ifdef ADDR_ALLOC_FREE_CNT_EN
  ,
  output logic [ADDR_W:0]   free_cnt
`endif
);

  import sram_pkg::*;

  alloc_state_e      state_q;
  logic [ADDR_W:0]   num_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] first_q;
  logic [DEPTH-1:0]  mask_q;
  logic [DEPTH-1:0]  used_q;
  logic [DEPTH-1:0]  used_d;
  logic              done_q;
  logic              ok_q;

  logic              commit;
  logic              bit_free;
  logic [ADDR_W:0]   cnt_inc;
  logic              last_idx;
  logic              scan_end;
  logic              req_short;

  // The grant is committed on the edge that leaves DONE; a release in the same
  // cycle wins over the commit for any bit it names.
  assign commit = (state_q == ST_DONE) && ok_q;

  always_comb begin
    used_d = used_q;
    if (commit) begin
      used_d = used_d | mask_q;
    end
    if (rel_req) begin
      used_d = used_d & ~rel_mask;
    end
  end

  assign bit_free = ~used_q[idx_q];
  assign cnt_inc  = cnt_q + (ADDR_W + 1)'(bit_free);
  assign last_idx = (idx_q == ADDR_W'(DEPTH - 1));
  assign scan_end = (cnt_inc == num_q) || last_idx;

`ifdef ADDR_ALLOC_FREE_CNT_EN
  logic [ADDR_W:0] free_cnt_q;
  logic [ADDR_W:0] used_pop;

  addr_popcnt #(
    .W  (DEPTH),
    .CW (ADDR_W + 1)
  ) u_popcnt (
    .vec_i (used_d),
    .cnt_o (used_pop)
  );

  // Tracks the bitmap as it will be after this edge, so commit and release
  // are both reflected without separate add/subtract paths.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      free_cnt_q <= (ADDR_W + 1)'(DEPTH);
    end else begin
      free_cnt_q <= (ADDR_W + 1)'(DEPTH) - used_pop;
    end
  end

  assign free_cnt  = free_cnt_q;
  assign req_short = (alloc_num == '0) || (alloc_num > free_cnt_q);
`else
  assign req_short = (alloc_num == '0);
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      num_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      first_q <= '0;
      mask_q  <= '0;
      used_q  <= '0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      used_q <= used_d;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (alloc_req) begin
            // Result registers are cleared on every accepted request so the
            // rejected/zero-length path reports an empty grant.
            num_q   <= alloc_num;
            cnt_q   <= '0;
            idx_q   <= '0;
            first_q <= '0;
            mask_q  <= '0;
            ok_q    <= 1'b0;
            if (req_short) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (bit_free) begin
            mask_q[idx_q] <= 1'b1;
            if (cnt_q == '0) begin
              first_q <= idx_q;
            end
          end
          cnt_q <= cnt_inc;
          idx_q <= idx_q + ADDR_W'(1);
          if (scan_end) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            ok_q    <= (cnt_inc == num_q);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign alloc_busy       = (state_q != ST_IDLE);
  assign alloc_done       = done_q;
  assign alloc_ok         = ok_q;
  assign alloc_mask       = mask_q;
  assign alloc_first_addr = first_q;
  assign alloc_grant_cnt  = cnt_q;

endmodule
